// File: rtl/phy_tx_if.sv
// Byte stream from the TX control mux into the USB PHY transmit stage.
interface phy_tx_if;
  logic       sop;
  logic       eop;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       cancle;

  modport master (output sop, eop, valid, data, cancle, input ready);
  modport slave  (input sop, eop, valid, data, cancle, output ready);
endinterface

// File: rtl/phy_tx.sv
// USB full-speed transmit serialiser: prepends SYNC, bit-stuffs, NRZI-encodes,
// appends EOP and drives the differential line from the TX mux byte stream.
module phy_tx #(
  parameter int BIT_DIV = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  phy_tx_if.slave tx_lp,
  output logic    usb_dp,
  output logic    usb_dm,
  output logic    usb_oe,
  output logic    tx_done,
  output logic    tx_err
);
  localparam int DW = $clog2(BIT_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(BIT_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_DATA  = 3'd2,
    S_ABORT = 3'd3,
    S_EOP   = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic           last_taken_q, last_taken_d;
  logic           abort_q, abort_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]     ones_q, ones_d;
  logic           dp_q, dp_d;
  logic           dm_q, dm_d;
  logic           oe_q, oe_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic tick_s, ready_s, acc_s, stuff_s, byte_end_s;
  logic nxt_bit_s, drive_s;

  // A 0 toggles J<->K, a 1 holds the line; the line is always J or K here.
  function automatic logic [1:0] nrzi(input logic bit_v, input logic dp_v);
    logic [1:0] line_v;
    if (bit_v) begin
      line_v = {dp_v, ~dp_v};
    end else begin
      line_v = {~dp_v, dp_v};
    end
    return line_v;
  endfunction

  assign tick_s     = (state_q != S_IDLE) && (div_q == DIV_MAX);
  assign ready_s    = (state_q == S_IDLE) ||
                      (((state_q == S_SYNC) || (state_q == S_DATA)) && !hold_full_q && !last_taken_q);
  assign acc_s      = tx_lp.valid && ready_s;
  assign stuff_s    = tick_s && ((state_q == S_SYNC) || (state_q == S_DATA)) && (ones_q == 3'd6);
  assign byte_end_s = tick_s && !stuff_s && (bit_cnt_q == 3'd7);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      hold_q       <= 8'h00;
      hold_full_q  <= 1'b0;
      last_taken_q <= 1'b0;
      abort_q      <= 1'b0;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      ones_q       <= 3'd0;
      dp_q         <= 1'b1;
      dm_q         <= 1'b0;
      oe_q         <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      last_taken_q <= last_taken_d;
      abort_q      <= abort_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      dp_q         <= dp_d;
      dm_q         <= dm_d;
      oe_q         <= oe_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (acc_s && tx_lp.sop && !tx_lp.cancle) begin
          state_d = S_SYNC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SYNC: begin
        if (byte_end_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_SYNC;
        end
      end
      S_DATA: begin
        if (byte_end_s) begin
          if (abort_q) begin
            state_d = S_ABORT;
          end else if (hold_full_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_EOP;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_ABORT: begin
        if (tick_s && (bit_cnt_q == 3'd6)) begin
          state_d = S_EOP;
        end else begin
          state_d = S_ABORT;
        end
      end
      S_EOP: begin
        if (tick_s && (bit_cnt_q == 3'd2)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_EOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, bit sequencing and line output values.
  always_comb begin
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    last_taken_d = last_taken_q;
    abort_d      = abort_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    dp_d         = dp_q;
    dm_d         = dm_q;
    oe_d         = oe_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    nxt_bit_s    = 1'b1;
    drive_s      = 1'b0;

    if (state_q == S_IDLE) begin
      div_d = '0;
    end else begin
      div_d = tick_s ? '0 : div_q + DIV_ONE;
    end

    // A cancelled byte is never stored; it only schedules the abort.
    if (acc_s && tx_lp.cancle) begin
      if (state_q != S_IDLE) begin
        last_taken_d = 1'b1;
        abort_d      = 1'b1;
      end else begin
        abort_d      = 1'b0;
      end
    end else if (acc_s && (tx_lp.sop || (state_q != S_IDLE))) begin
      hold_d       = tx_lp.data;
      hold_full_d  = 1'b1;
      last_taken_d = tx_lp.eop;
    end else begin
      hold_full_d  = hold_full_q;
    end

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = 3'd0;
        ones_d    = 3'd0;
        if (state_d == S_SYNC) begin
          dp_d = 1'b0;
          dm_d = 1'b1;
          oe_d = 1'b1;
        end else begin
          dp_d = 1'b1;
          dm_d = 1'b0;
          oe_d = 1'b0;
        end
      end
      S_SYNC, S_DATA: begin
        if (stuff_s) begin
          {dp_d, dm_d} = nrzi(1'b0, dp_q);
          ones_d       = 3'd0;
        end else if (tick_s && (bit_cnt_q != 3'd7)) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = shift_q >> 1;
          nxt_bit_s = (state_q == S_SYNC) ? (bit_cnt_q == 3'd6) : shift_q[1];
          drive_s   = 1'b1;
        end else if (tick_s && (state_d == S_DATA)) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = 3'd0;
          nxt_bit_s   = hold_q[0];
          drive_s     = 1'b1;
        end else if (tick_s && (state_d == S_ABORT)) begin
          bit_cnt_d = 3'd0;
          ones_d    = 3'd0;
        end else if (tick_s) begin
          bit_cnt_d = 3'd0;
          ones_d    = 3'd0;
          dp_d      = 1'b0;
          dm_d      = 1'b0;
          err_d     = !last_taken_q;
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      S_ABORT: begin
        if (tick_s && (bit_cnt_q == 3'd6)) begin
          bit_cnt_d = 3'd0;
          dp_d      = 1'b0;
          dm_d      = 1'b0;
        end else if (tick_s) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      S_EOP: begin
        if (tick_s) begin
          case (bit_cnt_q)
            3'd0: bit_cnt_d = 3'd1;
            3'd1: begin
              bit_cnt_d = 3'd2;
              dp_d      = 1'b1;
              dm_d      = 1'b0;
            end
            default: begin
              bit_cnt_d    = 3'd0;
              dp_d         = 1'b1;
              dm_d         = 1'b0;
              oe_d         = 1'b0;
              done_d       = 1'b1;
              hold_full_d  = 1'b0;
              last_taken_d = 1'b0;
              abort_d      = 1'b0;
            end
          endcase
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        bit_cnt_d = 3'd0;
      end
    endcase

    if (drive_s) begin
      {dp_d, dm_d} = nrzi(nxt_bit_s, dp_q);
      ones_d       = nxt_bit_s ? (ones_q + 3'd1) : 3'd0;
    end else begin
      drive_s = 1'b0;
    end
  end

  assign tx_lp.ready = ready_s;
  assign usb_dp      = dp_q;
  assign usb_dm      = dm_q;
  assign usb_oe      = oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
endmodule

// File: tb/tb_phy_tx.sv
// Directed, table-driven bench for phy_tx: line symbols sampled mid-bit are
// compared against hand-encoded SYNC/data/stuff/EOP sequences.
module tb_phy_tx;
  localparam int BIT_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic usb_dp, usb_dm, usb_oe, tx_done, tx_err;

  phy_tx_if lp();

  phy_tx #(.BIT_DIV(BIT_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_lp   (lp),
    .usb_dp  (usb_dp),
    .usb_dm  (usb_dm),
    .usb_oe  (usb_oe),
    .tx_done (tx_done),
    .tx_err  (tx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         nb;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       eop_last;
    logic       cancel2;
    string      exp_line;
    int         exp_oe;
    int         exp_err;
  } vec_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    mon_oe = 0, mon_done = 0, mon_err = 0, done_good = 0;
  int    oe_run = 0, oe_rise_cyc = 0, err_cyc = 0;
  logic  prev_oe = 1'b0;
  string line_acc = "";

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sym(input logic dp, input logic dm);
    if (dp && !dm) return "J";
    else if (!dp && dm) return "K";
    else if (!dp && !dm) return "0";
    else return "X";
  endfunction

  // Line monitor: one symbol per bit time, sampled mid-bit while oe is high.
  always @(negedge clk) begin
    if (usb_oe) begin
      if ((oe_run % BIT_DIV) == (BIT_DIV / 2)) line_acc <= {line_acc, sym(usb_dp, usb_dm)};
      if (!prev_oe) oe_rise_cyc <= cyc;
      oe_run <= oe_run + 1;
      mon_oe <= mon_oe + 1;
    end else begin
      oe_run <= 0;
    end
    if (tx_done) begin
      mon_done <= mon_done + 1;
      if (!usb_oe && prev_oe) done_good <= done_good + 1;
    end
    if (tx_err) begin
      mon_err <= mon_err + 1;
      err_cyc <= cyc;
    end
    prev_oe <= usb_oe;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got '%s', expected '%s'", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; acc is the cycle before the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic s, input logic e,
                           input logic c, output int acc);
    int n;
    lp.data = d; lp.sop = s; lp.eop = e; lp.cancle = c; lp.valid = 1'b1;
    n = 0;
    while ((lp.ready !== 1'b1) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (n >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept timeout: ready low for %0d cycles, expected accept", n);
    end
    @(negedge clk);
    lp.valid = 1'b0; lp.sop = 1'b0; lp.eop = 1'b0; lp.cancle = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n;
    n = 0;
    while ((mon_done == d0) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s done timeout: got no tx_done in %0d cycles, expected one", name, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int o0, d0, e0, g0, l0, a0, a1;
    string got;
    o0 = mon_oe; d0 = mon_done; e0 = mon_err; g0 = done_good; l0 = line_acc.len();
    send_byte(v.b0, 1'b1, (v.nb == 1) ? v.eop_last : 1'b0, 1'b0, a0);
    if (v.nb == 2) begin
      send_byte(v.b1, 1'b0, v.eop_last, v.cancel2, a1);
      chk({v.name, " accept gap"}, a1 - a0, 8 * BIT_DIV + 1);
    end
    wait_done(d0, v.name);
    got = line_acc.substr(l0, line_acc.len() - 1);
    chk({v.name, " sync start"}, oe_rise_cyc, a0 + 1);
    chk_str({v.name, " line"}, got, v.exp_line);
    chk({v.name, " oe cycles"}, mon_oe - o0, v.exp_oe);
    chk({v.name, " err pulses"}, mon_err - e0, v.exp_err);
    if (v.exp_err != 0) chk({v.name, " err cycle"}, err_cyc, a0 + 1 + 16 * BIT_DIV);
    chk({v.name, " done pulses"}, mon_done - d0, 1);
    chk({v.name, " done at oe fall"}, done_good - g0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[7];
    string sync_s, eop_s;
    int    o0, d0, a0, a1, dummy;

    sync_s = "KJKJKJKK";
    eop_s  = "00J";
    tbl[0] = '{"a5",       1, 8'hA5, 8'h00, 1'b1, 1'b0, {sync_s, "KJJKJJKK", eop_s}, 76, 0};
    tbl[1] = '{"ffff",     2, 8'hFF, 8'hFF, 1'b1, 1'b0, {sync_s, "KKKKKJJJJJJJKKKKKK", eop_s}, 116, 0};
    tbl[2] = '{"3f",       1, 8'h3F, 8'h00, 1'b1, 1'b0, {sync_s, "KKKKKJJKJ", eop_s}, 80, 0};
    tbl[3] = '{"fc",       1, 8'hFC, 8'h00, 1'b1, 1'b0, {sync_s, "JKKKKKKKJ", eop_s}, 80, 0};
    tbl[4] = '{"underrun", 1, 8'h01, 8'h00, 1'b0, 1'b0, {sync_s, "KJKJKJKJ", eop_s}, 76, 1};
    tbl[5] = '{"cancel",   2, 8'h55, 8'hAA, 1'b0, 1'b1, {sync_s, "KJJKKJJK", "KKKKKKK", eop_s}, 104, 0};
    tbl[6] = '{"holdfull", 2, 8'h81, 8'h3C, 1'b1, 1'b0, {sync_s, "KJKJKJKK", "JKKKKKJK", eop_s}, 108, 0};

    lp.sop = 1'b0; lp.eop = 1'b0; lp.valid = 1'b0; lp.data = 8'h00; lp.cancle = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset dp", int'(usb_dp), 1);
    chk("reset dm", int'(usb_dm), 0);
    chk("reset oe", int'(usb_oe), 0);
    chk("reset done", int'(tx_done), 0);
    chk("reset err", int'(tx_err), 0);
    chk("reset ready", int'(lp.ready), 1);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Idle-only traffic: bytes without sop, and sop with cancel, never start a packet.
    o0 = mon_oe;
    send_byte(8'h55, 1'b0, 1'b1, 1'b0, dummy);
    repeat (20) @(negedge clk);
    chk("idle no-sop discarded", mon_oe - o0, 0);
    send_byte(8'hFF, 1'b1, 1'b1, 1'b1, dummy);
    repeat (20) @(negedge clk);
    chk("idle sop+cancel dropped", mon_oe - o0, 0);

    // Reset during byte 2 abandons the packet without EOP or tx_done.
    send_byte(8'h12, 1'b1, 1'b0, 1'b0, a0);
    send_byte(8'h34, 1'b0, 1'b1, 1'b0, a1);
    repeat (40) @(negedge clk);
    d0 = mon_done;
    rst_n = 1'b0;
    #1;
    chk("midreset dp", int'(usb_dp), 1);
    chk("midreset dm", int'(usb_dm), 0);
    chk("midreset oe", int'(usb_oe), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("midreset no done", mon_done - d0, 0);
    run_vec(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/phy_tx.md
# phy_tx

Serialising transmit stage of the USB PHY. Consumes the byte stream produced by the TX control mux (sop/eop/valid/ready/data/cancle), prepends SYNC, applies bit stuffing and NRZI encoding, appends EOP, and drives the full-speed differential line. It is the sink for `tx_lp_*`; its `tx_lp_ready` is the backpressure seen by the mux.

## Interface
- `BIT_DIV`, 4, clock cycles per USB bit time (≥2).
- `clk` in 1: single clock. Rising edge only.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_lp_sop` in 1: first byte of packet.
- `tx_lp_eop` in 1: last byte of packet.
- `tx_lp_valid` in 1: byte valid.
- `tx_lp_ready` out 1: byte accepted when `valid & ready` (combinational).
- `tx_lp_data` in 8: byte, sent LSB first.
- `tx_lp_cancle` in 1: abort packet, sampled with an accepted byte.
- `usb_dp` / `usb_dm` out 1 each: line drive. J = 1/0, K = 0/1, SE0 = 0/0.
- `usb_oe` out 1: transceiver output enable.
- `tx_done` out 1: one-cycle pulse when the line returns to idle after EOP.
- `tx_err` out 1: one-cycle pulse on underrun.

## Operation
- Datapath: 1-byte holding register (`hold`, `hold_full`, `hold_eop`) feeding an 8-bit shift register. Bit-rate divider counts 0..BIT_DIV-1 while not IDLE. `tick` = divider at BIT_DIV-1. Line outputs change only on a tick, or on entry from IDLE.
- `tx_lp_ready` = IDLE, or (SYNC|DATA & ~hold_full & ~last_taken). It is 0 in EOP/ABORT.
- Bytes accepted in IDLE without sop are consumed and discarded. sop seen mid-packet is treated as plain data.
- FSM:
  - **IDLE**: `oe`=0, line J. An accepted byte with sop loads `hold`, sets `last_taken` if eop, and moves to SYNC.
  - **SYNC**: sends 0x80 LSB first (KJKJKJKK) with `oe`=1. After 8 bits, loads the shift register from `hold` and moves to DATA.
  - **DATA**: one bit per tick. At a byte boundary:
    - if `hold_full`, reload the shift register from `hold`;
    - else if the last byte has been sent, go to EOP;
    - else pulse `tx_err` and go to EOP (underrun).
  - **ABORT**: entered when a byte is accepted with `tx_lp_cancle`=1; that byte is not transmitted. Sends 7 one-bits with stuffing suppressed (no line transition), then goes to EOP.
  - **EOP**: SE0 for 2 bit times, then J for 1 bit time with `oe`=1. Then `oe`=0, pulse `tx_done`, go to IDLE.
- Bit stuffing:
  - The ones-counter includes the final 1 of SYNC.
  - After 6 consecutive 1s, insert a 0 and hold the shift register for that bit time. A 0 or a stuffed bit clears the counter.
  - The counter carries across byte boundaries.
  - A stuff bit due after the last data bit is sent before EOP.
- NRZI: a 0 bit (data or stuffed) toggles J↔K; a 1 bit holds the line. The first SYNC bit is K, referenced from idle J.
- `tx_lp_cancle` in IDLE with sop: the packet is dropped; no SYNC is sent.

## Timing
- Reset values: `usb_dp`=1, `usb_dm`=0, `usb_oe`=0, `tx_done`=0, `tx_err`=0, FSM=IDLE, holding register empty, counters 0. `tx_lp_ready` reads 1 after reset because the FSM is in IDLE.
- Reset asserted mid-packet: outputs go to reset values immediately and the packet is abandoned. No EOP is emitted.
- sop byte accepted at cycle T: `usb_oe`=1 and the first SYNC K appear at T+1. Each bit lasts BIT_DIV cycles.
- Packet of N bytes with S stuffed bits: `usb_oe` is high for exactly (8 + 8N + S + 3)·BIT_DIV cycles. `tx_done` pulses in the first cycle with `oe`=0.
- The holding register refills in the cycle after a shift-register load. Upstream therefore has 8·BIT_DIV−1 cycles to present the next byte.
- A byte held valid while ready=0 stays pending and is never lost or duplicated.

## Test plan
- Single byte 0xA5, sop&eop, BIT_DIV=4:
  - line shows KJKJKJKK;
  - data bits 1,0,1,0,0,1,0,1 are NRZI-encoded;
  - then SE0, SE0, J;
  - `oe` high 76 cycles, one `tx_done` pulse, S=0.
- Bytes 0xFF,0xFF:
  - stuff bits after data bits 5 and 11 (counted with the SYNC's trailing 1);
  - `oe` high 116 cycles.
- sop byte 0x01 (no eop), then `valid` held low:
  - `tx_err` pulses at the first byte boundary after 0x01;
  - EOP follows, then `tx_done`.
- 3-byte packet, second byte accepted with `tx_lp_cancle`=1:
  - byte 1 is sent, then 7 bit times with no transition;
  - then SE0, SE0, J;
  - `tx_err`=0.
- Upstream holds `valid` with 0x3C while `hold_full`:
  - `ready`=0 until the shift register loads;
  - the byte is accepted exactly once and appears on the line intact.
- `rst_n` pulsed low during byte 2 of a packet:
  - `usb_dp`=1, `usb_dm`=0, `usb_oe`=0 asynchronously;
  - no `tx_done`;
  - the next sop packet transmits normally.
